stack_engine: RTL and testbench

STACK_ENGINE -- requirements
Module: stack_engine

---
 rtl/stacker_pkg.sv | 19 +
 rtl/stack_tick_gen.sv | 31 +++
 rtl/stack_engine.sv | 173 +++++++++++++++++
 tb/tb_stack_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stacker_pkg.sv
// Shared encodings for the stacker game engine: FSM states, travel direction
// and the width of the tick period bus.
package stacker_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2,
        S_WIN  = 2'd3
    } state_t;

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } dir_t;

    localparam int PERIOD_W = 32;

endpackage

// File: rtl/stack_tick_gen.sv
// Move-tick timer: counts enabled cycles since the last clear and pulses tick
// once every `period` cycles. The count freezes while hold is high.
module stack_tick_gen
    import stacker_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                hold,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt} + (PERIOD_W+1)'(1);

    // >= rather than == so a period that shrinks below the current count
    // still produces a tick instead of wrapping the counter.
    assign tick = !hold && (cnt_inc >= {1'b0, period});

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= tick ? '0 : cnt_inc[PERIOD_W-1:0];
        end
    end

endmodule

// File: rtl/stack_engine.sv
// Stacker game engine: a block bounces across the field and is locked onto
// the stack on drop. Optional speed-up with height under STACK_SPEEDUP_EN.
//
// state | meaning
// IDLE  | waiting for start, outputs held
// RUN   | block moving, drops accepted
// OVER  | drop missed the stack, waiting for start
// WIN   | MAX_H rows locked, waiting for start
module stack_engine
    import stacker_pkg::*;
#(
    parameter int FIELD_W    = 40,
    parameter int MAX_H      = 15,
    parameter int INIT_W     = 6,
    parameter int TICK_DIV   = 2500000,
    parameter int SPEED_STEP = 100000,
    parameter int TICK_MIN   = 500000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         drop,
    input  logic                         pause,
    output logic [$clog2(FIELD_W)-1:0]   pos_x,
    output logic [$clog2(FIELD_W+1)-1:0] blk_w,
    output logic [$clog2(FIELD_W)-1:0]   base_x,
    output logic [$clog2(FIELD_W+1)-1:0] base_w,
    output logic [$clog2(MAX_H+1)-1:0]   height,
    output logic [1:0]                   state,
    output logic                         game_over,
    output logic                         win
);

    localparam int PW = $clog2(FIELD_W);
    localparam int BW = $clog2(FIELD_W+1);
    localparam int HW = $clog2(MAX_H+1);
    localparam int XW = PW + 1;

    state_t        state_q, state_n;
    dir_t          dir_q, dir_n;
    logic [PW-1:0] pos_q, pos_n, bx_q, bx_n;
    logic [BW-1:0] w_q, w_n, bw_q, bw_n;
    logic [HW-1:0] h_q, h_n, h_inc;
    logic          over_q, win_q;
    logic          clr, hold, tick;

    logic [PERIOD_W-1:0] period;
    logic [XW-1:0]       pos_ext, bx_ext, p_r, b_r, ov_l, ov_r, ov_w;

`ifdef STACK_SPEEDUP_EN
    logic [PERIOD_W-1:0] dec;

    assign dec    = PERIOD_W'(h_q) * PERIOD_W'(SPEED_STEP);
    assign period = (dec < PERIOD_W'(TICK_DIV) &&
                     (PERIOD_W'(TICK_DIV) - dec) > PERIOD_W'(TICK_MIN))
                    ? PERIOD_W'(TICK_DIV) - dec : PERIOD_W'(TICK_MIN);
`else
    // Speed-up parameters have no effect in this build.
    logic [63:0] unused_speed_cfg;

    assign unused_speed_cfg = {32'(SPEED_STEP), 32'(TICK_MIN)};
    assign period           = PERIOD_W'(TICK_DIV);
`endif

    assign hold = pause || (state_q != S_RUN);

    stack_tick_gen u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .hold   (hold),
        .period (period),
        .tick   (tick)
    );

    // Overlap is done one bit wider than pos_x so right edges never wrap.
    assign pos_ext = XW'(pos_q);
    assign bx_ext  = XW'(bx_q);
    assign p_r     = pos_ext + XW'(w_q);
    assign b_r     = bx_ext + XW'(bw_q);
    assign ov_l    = (h_q == '0) ? pos_ext : ((pos_ext > bx_ext) ? pos_ext : bx_ext);
    assign ov_r    = (h_q == '0) ? p_r : ((p_r < b_r) ? p_r : b_r);
    assign ov_w    = (ov_r > ov_l) ? (ov_r - ov_l) : '0;
    assign h_inc   = h_q + HW'(1);

    always_comb begin
        state_n = state_q;
        dir_n   = dir_q;
        pos_n   = pos_q;
        w_n     = w_q;
        bx_n    = bx_q;
        bw_n    = bw_q;
        h_n     = h_q;
        clr     = 1'b0;

        if (start) begin
            state_n = S_RUN;
            pos_n   = '0;
            dir_n   = RIGHT;
            w_n     = BW'(INIT_W);
            h_n     = '0;
            bw_n    = '0;
            clr     = 1'b1;
        end else if (state_q == S_RUN && !pause) begin
            if (drop) begin
                clr = 1'b1;
                if (ov_w == '0) begin
                    state_n = S_OVER;
                end else begin
                    bx_n  = PW'(ov_l);
                    bw_n  = BW'(ov_w);
                    w_n   = BW'(ov_w);
                    h_n   = h_inc;
                    pos_n = '0;
                    dir_n = RIGHT;
                    if (h_inc == HW'(MAX_H)) begin
                        state_n = S_WIN;
                    end
                end
            end else if (tick && w_q != BW'(FIELD_W)) begin
                if (dir_q == RIGHT) begin
                    if (p_r == XW'(FIELD_W)) begin
                        dir_n = LEFT;
                        pos_n = pos_q - PW'(1);
                    end else begin
                        pos_n = pos_q + PW'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        dir_n = RIGHT;
                        pos_n = pos_q + PW'(1);
                    end else begin
                        pos_n = pos_q - PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dir_q   <= RIGHT;
            pos_q   <= '0;
            w_q     <= '0;
            bx_q    <= '0;
            bw_q    <= '0;
            h_q     <= '0;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            dir_q   <= dir_n;
            pos_q   <= pos_n;
            w_q     <= w_n;
            bx_q    <= bx_n;
            bw_q    <= bw_n;
            h_q     <= h_n;
            over_q  <= (state_n == S_OVER);
            win_q   <= (state_n == S_WIN);
        end
    end

    assign pos_x     = pos_q;
    assign blk_w     = w_q;
    assign base_x    = bx_q;
    assign base_w    = bw_q;
    assign height    = h_q;
    assign state     = state_q;
    assign game_over = over_q;
    assign win       = win_q;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the game rules.
module tb_stack_engine;

    localparam int FIELD_W  = 8;
    localparam int MAX_H    = 4;
    localparam int INIT_W   = 3;
    localparam int TICK_DIV = 4;

    logic       clk;
    logic       rst, start, drop, pause;
    logic [2:0] pos_x, base_x;
    logic [3:0] blk_w, base_w;
    logic [2:0] height;
    logic [1:0] state;
    logic       game_over, win;

    int n_checks = 0;
    int n_pass   = 0;

    // model: state 0 idle, 1 run, 2 over, 3 win; dir 0 right, 1 left
    int m_state, m_pos, m_dir, m_w, m_bx, m_bw, m_h, m_elapsed;

    stack_engine #(
        .FIELD_W  (FIELD_W),
        .MAX_H    (MAX_H),
        .INIT_W   (INIT_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .drop      (drop),
        .pause     (pause),
        .pos_x     (pos_x),
        .blk_w     (blk_w),
        .base_x    (base_x),
        .base_w    (base_w),
        .height    (height),
        .state     (state),
        .game_over (game_over),
        .win       (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model(input logic r, input logic s, input logic d, input logic p);
        int l, rr, ow;
        if (r) begin
            m_state = 0; m_pos = 0; m_dir = 0; m_w = 0; m_bx = 0; m_bw = 0; m_h = 0; m_elapsed = 0;
        end else if (s) begin
            m_state = 1; m_pos = 0; m_dir = 0; m_w = INIT_W; m_h = 0; m_bw = 0; m_elapsed = 0;
        end else if (m_state == 1 && !p) begin
            if (d) begin
                if (m_h == 0) begin
                    l = m_pos; ow = m_w;
                end else begin
                    l  = (m_pos > m_bx) ? m_pos : m_bx;
                    rr = (m_pos + m_w < m_bx + m_bw) ? m_pos + m_w : m_bx + m_bw;
                    ow = (rr > l) ? rr - l : 0;
                end
                m_elapsed = 0;
                if (ow == 0) begin
                    m_state = 2;
                end else begin
                    m_bx = l; m_bw = ow; m_w = ow; m_h++; m_pos = 0; m_dir = 0;
                    if (m_h == MAX_H) m_state = 3;
                end
            end else begin
                m_elapsed++;
                if (m_elapsed == TICK_DIV) begin
                    m_elapsed = 0;
                    if (m_w != FIELD_W) begin
                        if (m_dir == 0) begin
                            if (m_pos + m_w == FIELD_W) begin m_dir = 1; m_pos--; end
                            else m_pos++;
                        end else begin
                            if (m_pos == 0) begin m_dir = 0; m_pos++; end
                            else m_pos--;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic d, input logic p);
        rst = r; start = s; drop = d; pause = p;
        @(posedge clk);
        model(r, s, d, p);
        #1;
        rst = 1'b0; start = 1'b0; drop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({state, pos_x, blk_w, base_x, base_w, height, game_over, win} !== 23'd0)
            $display("FAIL reset_values: got %h expected 0",
                     {state, pos_x, blk_w, base_x, base_w, height, game_over, win});
        else n_pass++;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (state !== 2'd0 || pos_x !== 3'd0 || height !== 3'd0)
            $display("FAIL idle_drop: state %0d pos %0d height %0d expected 0 0 0", state, pos_x, height);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int exp_pos[7] = '{1, 2, 3, 4, 5, 4, 3};
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (state !== 2'd1 || pos_x !== 3'd0 || blk_w !== 4'd3)
            $display("FAIL start_run: state %0d pos %0d blk_w %0d expected 1 0 3", state, pos_x, blk_w);
        else n_pass++;
        for (int t = 0; t < 7; t++) begin
            idle(3);
            n_checks++;
            if (pos_x !== 3'(m_pos) || m_pos != (t == 0 ? 0 : exp_pos[t-1]))
                $display("FAIL pre_tick_%0d: pos %0d expected %0d", t, pos_x, m_pos);
            else n_pass++;
            idle(1);
            n_checks++;
            if (pos_x !== 3'(exp_pos[t]))
                $display("FAIL bounce_tick_%0d: pos %0d expected %0d", t, pos_x, exp_pos[t]);
            else n_pass++;
        end
    endtask

    task automatic test_drop_overlap();
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (height !== 3'd1 || base_x !== 3'd2 || base_w !== 4'd3 || pos_x !== 3'd0)
            $display("FAIL drop_first: h %0d bx %0d bw %0d pos %0d expected 1 2 3 0",
                     height, base_x, base_w, pos_x);
        else n_pass++;
        idle(12);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (height !== 3'd2 || base_x !== 3'd3 || base_w !== 4'd2 || blk_w !== 4'd2)
            $display("FAIL drop_partial: h %0d bx %0d bw %0d w %0d expected 2 3 2 2",
                     height, base_x, base_w, blk_w);
        else n_pass++;
    endtask

    task automatic test_over();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (state !== 2'd2 || game_over !== 1'b1 || height !== 3'd2 || base_x !== 3'd3)
            $display("FAIL miss_over: state %0d go %0d h %0d bx %0d expected 2 1 2 3",
                     state, game_over, height, base_x);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (state !== 2'd2 || height !== 3'd2)
            $display("FAIL over_drop: state %0d h %0d expected 2 2", state, height);
        else n_pass++;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (state !== 2'd1 || height !== 3'd0 || blk_w !== 4'd3 || game_over !== 1'b0 || base_w !== 4'd0)
            $display("FAIL restart: state %0d h %0d w %0d go %0d bw %0d expected 1 0 3 0 0",
                     state, height, blk_w, game_over, base_w);
        else n_pass++;
    endtask

    task automatic test_win();
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (height !== 3'(i) || state !== (i == 4 ? 2'd3 : 2'd1))
                $display("FAIL win_drop_%0d: h %0d state %0d expected %0d %0d",
                         i, height, state, i, (i == 4) ? 3 : 1);
            else n_pass++;
        end
        n_checks++;
        if (win !== 1'b1 || game_over !== 1'b0)
            $display("FAIL win_flag: win %0d go %0d expected 1 0", win, game_over);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        n_checks++;
        if (state !== 2'd3 || height !== 3'd4 || pos_x !== 3'd0)
            $display("FAIL win_hold: state %0d h %0d pos %0d expected 3 4 0", state, height, pos_x);
        else n_pass++;
    endtask

    task automatic test_tick_priority();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (pos_x !== 3'd0 || height !== 3'd1 || base_x !== 3'd1 || base_w !== 4'd3)
            $display("FAIL drop_vs_tick: pos %0d h %0d bx %0d bw %0d expected 0 1 1 3",
                     pos_x, height, base_x, base_w);
        else n_pass++;
        idle(3);
        n_checks++;
        if (pos_x !== 3'd0)
            $display("FAIL tick_cleared: pos %0d expected 0", pos_x);
        else n_pass++;
        idle(1);
        n_checks++;
        if (pos_x !== 3'd1)
            $display("FAIL tick_after_drop: pos %0d expected 1", pos_x);
        else n_pass++;
    endtask

    task automatic test_pause();
        idle(2);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, (i % 3) == 0, 1'b1);
            n_checks++;
            if (pos_x !== 3'd1 || height !== 3'd1 || state !== 2'd1)
                $display("FAIL pause_%0d: pos %0d h %0d state %0d expected 1 1 1",
                         i, pos_x, height, state);
            else n_pass++;
        end
        idle(1);
        n_checks++;
        if (pos_x !== 3'd1)
            $display("FAIL pause_resume_hold: pos %0d expected 1", pos_x);
        else n_pass++;
        idle(1);
        n_checks++;
        if (pos_x !== 3'd2)
            $display("FAIL pause_resume_tick: pos %0d expected 2", pos_x);
        else n_pass++;
    endtask

    task automatic test_rst_mid();
        idle(5);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({state, pos_x, blk_w, base_x, base_w, height, game_over, win} !== 23'd0)
            $display("FAIL rst_mid_run: got %h expected 0",
                     {state, pos_x, blk_w, base_x, base_w, height, game_over, win});
        else n_pass++;
    endtask

    task automatic test_random();
        logic r, s, d, p;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom % 300) == 0;
            s = ($urandom % 50) == 0;
            d = ($urandom % 7) == 0;
            p = ($urandom % 5) == 0;
            step(r, s, d, p);
            n_checks++;
            if (state !== 2'(m_state) || pos_x !== 3'(m_pos) || blk_w !== 4'(m_w) ||
                base_x !== 3'(m_bx) || base_w !== 4'(m_bw) || height !== 3'(m_h) ||
                game_over !== (m_state == 2) || win !== (m_state == 3))
                $display("FAIL random_%0d: st %0d pos %0d w %0d bx %0d bw %0d h %0d go %0d win %0d expected %0d %0d %0d %0d %0d %0d",
                         i, state, pos_x, blk_w, base_x, base_w, height, game_over, win,
                         m_state, m_pos, m_w, m_bx, m_bw, m_h);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; drop = 1'b0; pause = 1'b0;
        m_state = 0; m_pos = 0; m_dir = 0; m_w = 0; m_bx = 0; m_bw = 0; m_h = 0; m_elapsed = 0;
        test_reset();
        test_bounce();
        test_drop_overlap();
        test_over();
        test_win();
        test_tick_priority();
        test_pause();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
